// File: rtl/line_word_arbiter.sv
// ---------------------------------------------------------------------------
// line_word_arbiter
//
// Shares one resident 256-bit cache line and its 8-to-1 word-select datapath
// between NREQ word requesters. Requesters are granted round-robin. The
// winner's tag is compared against the single resident line. On a hit the
// addressed 32-bit word is returned on the next cycle. On a miss the line is
// fetched from the memory side first, and the word is returned on the cycle
// after mem_rvalid.
//
// Address split: tag = addr[AW-1:5], word offset = addr[4:2], addr[1:0] is
// ignored. Offset 0 selects line[255:224] and offset 7 selects line[31:0].
//
// Handshakes:
//   A requester raises req_valid[i] with req_addr[i*AW +: AW] and holds both
//   until it sees resp_valid[i]. resp_valid[i] is a one-cycle pulse. In the
//   following cycle req_valid[i] must be low or carry a new request. On the
//   memory side, mem_req/mem_addr stay high and stable until the one-cycle
//   mem_rvalid pulse. mem_rvalid is ignored outside a fetch.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req_valid   per-requester request valid   (NREQ)
//   req_addr    packed byte addresses         (NREQ*AW)
//   resp_valid  one-hot response pulse        (NREQ)
//   resp_data   returned word                 (32)
//   flush       invalidates the resident line
//   mem_req     line fetch request
//   mem_addr    line address                  (AW-5)
//   mem_rvalid  fill data valid pulse
//   mem_rdata   fill line                     (256)
//   hit_cnt, miss_cnt  saturating lookup counters (32 each),
//                      present only when LWA_PERF_CNT_EN is defined
//
// Optional feature macro: LWA_PERF_CNT_EN
// ---------------------------------------------------------------------------
module line_word_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_data,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [AW-6:0]        mem_addr,
    input  logic                 mem_rvalid,
    input  logic [255:0]         mem_rdata
`ifdef LWA_PERF_CNT_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = AW - 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     id_q;
    logic [TW-1:0]     tag_q;
    logic [2:0]        off_q;
    logic              line_valid_q;
    logic [TW-1:0]     line_tag_q;
    logic [255:0]      line_q;
    logic [NREQ-1:0]   resp_valid_q;
    logic [31:0]       resp_data_q;
    logic              mem_req_q;
    logic [TW-1:0]     mem_addr_q;

    // Per-requester address view of the packed bus.
    logic [AW-1:0]     addr_arr [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign addr_arr[i] = req_addr[i*AW +: AW];
    end

    // Round-robin grant: first valid requester at or after ptr_q, wrapping.
    logic              gnt_valid;
    logic [PW-1:0]     gnt_id;
    logic [PW-1:0]     cand;
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_valid && req_valid[cand]) begin
                gnt_valid = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    logic [AW-1:0]     gnt_addr;
    logic [TW-1:0]     gnt_tag;
    logic [2:0]        gnt_off;
    logic              gnt_hit;
    logic [NREQ-1:0]   gnt_onehot;
    logic [NREQ-1:0]   id_onehot;
    logic [PW-1:0]     ptr_next;
    logic              unused_addr_bits;

    assign gnt_addr   = addr_arr[gnt_id];
    assign gnt_tag    = gnt_addr[AW-1:5];
    assign gnt_off    = gnt_addr[4:2];
    assign unused_addr_bits = ^gnt_addr[1:0];
    // A flush in the capture cycle forces the lookup to miss.
    assign gnt_hit    = line_valid_q && !flush && (line_tag_q == gnt_tag);
    assign gnt_onehot = NREQ'(1) << gnt_id;
    assign id_onehot  = NREQ'(1) << id_q;
    assign ptr_next   = (id_q == PW'(NREQ - 1)) ? '0 : id_q + PW'(1);

    function automatic logic [31:0] word_sel(input logic [255:0] line,
                                             input logic [2:0]   off);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (off == 3'(k)) w = line[255 - 32*k -: 32];
        end
        return w;
    endfunction

`ifdef LWA_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            tag_q        <= '0;
            off_q        <= '0;
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
`ifdef LWA_PERF_CNT_EN
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid) begin
                        id_q  <= gnt_id;
                        tag_q <= gnt_tag;
                        off_q <= gnt_off;
                        if (gnt_hit) begin
                            resp_valid_q <= gnt_onehot;
                            resp_data_q  <= word_sel(line_q, gnt_off);
                            state_q      <= S_RESP;
`ifdef LWA_PERF_CNT_EN
                            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= gnt_tag;
                            state_q    <= S_FETCH;
`ifdef LWA_PERF_CNT_EN
                            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_rvalid) begin
                        line_q       <= mem_rdata;
                        line_tag_q   <= tag_q;
                        line_valid_q <= 1'b1;
                        mem_req_q    <= 1'b0;
                        // The word comes straight from the fill data so it is
                        // returned even if a flush drops the line this cycle.
                        resp_valid_q <= id_onehot;
                        resp_data_q  <= word_sel(mem_rdata, off_q);
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid_q <= '0;
                    ptr_q        <= ptr_next;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Placed last so a flush wins over a same-cycle fill.
            if (flush) line_valid_q <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
`ifdef LWA_PERF_CNT_EN
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;
`endif

endmodule

// File: doc/line_word_arbiter.md
Name: line_word_arbiter

Overview:
- Shares one cached 256-bit line buffer and its 8-to-1 word-select datapath between NREQ word requesters, for example instruction and data ports.
- Arbitrates round-robin and checks the tag of the single resident line.
- On a miss, fetches the 256-bit line from the memory side, then returns the addressed 32-bit word.
- Sits between the requester ports and the line-fill memory interface.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 32, byte address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request; held until that requester's resp_valid
- req_addr  in  NREQ*AW  packed byte addresses, requester i at [i*AW +: AW]
- resp_valid  out  NREQ  one-hot; one-cycle pulse to the served requester
- resp_data  out  32  returned word; valid only while resp_valid != 0
- flush  in  1  invalidates the resident line
- mem_req  out  1  line fetch request; held high until mem_rvalid
- mem_addr  out  AW-5  line address, req_addr[AW-1:5] of the captured request
- mem_rvalid  in  1  fill data valid; one-cycle pulse
- mem_rdata  in  256  fill line

Behaviour:
- Address split:
  - tag = addr[AW-1:5]
  - word offset = addr[4:2]
  - addr[1:0] ignored
- Word select: offset 0 returns line[255:224], offset 1 returns line[223:192], and so on; offset 7 returns line[31:0].
- Reset values:
  - state IDLE
  - resp_valid 0, resp_data 0, mem_req 0, mem_addr 0
  - line_valid 0
  - round-robin pointer 0
  - line data need not be reset
- IDLE:
  - If any req_valid is high, grant the first requester at or after the pointer, wrapping modulo NREQ.
  - Capture the winner's id and address at the clock edge.
  - If line_valid and tag match (evaluated with the capture), go to RESP; otherwise go to FETCH.
- FETCH:
  - mem_req = 1 and mem_addr = captured tag, both stable for the whole state.
  - On mem_rvalid: load the line, set tag, set line_valid, go to RESP.
  - mem_rvalid outside FETCH is ignored.
- RESP:
  - resp_valid[id] = 1 and resp_data = selected word, both registered outputs for exactly one cycle.
  - Pointer becomes (id+1) mod NREQ.
  - Go to IDLE.
- Latency (counted from the IDLE cycle in which the grant occurs):
  - Hit: resp_valid on the following cycle.
  - Miss: resp_valid on the cycle after the mem_rvalid cycle.
- Requester rule:
  - req_valid must be low, or carry a new request, in the cycle after its resp_valid.
  - Back-to-back requests from the same requester are legal; the pointer ensures others are served first.
- Throughput: at most one response every 2 cycles on a hit (IDLE + RESP).
- Flush:
  - Clears line_valid at the clock edge in any state.
  - If flush coincides with an IDLE capture, the lookup is treated as a miss.
  - If flush coincides with mem_rvalid in FETCH, the fetched word is still returned but line_valid ends 0.
- Reset mid-operation:
  - Returns to IDLE and drops mem_req next cycle.
  - The pending request is discarded with no resp_valid; the requester must reissue.
- No other state holds mem_req high.
- resp_valid is never asserted for more than one requester at once.

Optional Feature:
- Macro: LWA_PERF_CNT_EN.
- When defined:
  - Adds outputs hit_cnt (32) and miss_cnt (32), both reset to 0.
  - Increment at the IDLE capture on hit or miss respectively.
  - Saturate at 32'hFFFF_FFFF.
  - A flush-forced miss counts as a miss.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, req0 addr 0x0000_0104; mem_rvalid 3 cycles after mem_req with line word pattern 0xA0..0xA7 (word k = 0xA0+k at the k-th 32-bit slot from the MSB end).
  - Required: mem_addr = 0x0000008; resp_valid = 01, resp_data = 0x000000A1, one cycle after mem_rvalid.
- Hit:
  - Stimulus: then req1 addr 0x0000_011C.
  - Required: no mem_req; resp_valid = 10 one cycle after grant; resp_data = 0x000000A7.
- Round-robin:
  - Stimulus: req0 and req1 continuously valid, same line, pointer 0.
  - Required: responses alternate 01, 10, 01, 10, one every 2 cycles.
- Flush:
  - Stimulus: flush pulsed while idle with a valid line, then req0 to the same line.
  - Required: mem_req asserts (miss).
  - Stimulus: flush asserted on the same cycle as mem_rvalid.
  - Required: the word is still returned; a subsequent same-line request misses again.
- Reset mid-fetch:
  - Stimulus: rst during FETCH.
  - Required: the next cycle shows mem_req = 0, no resp_valid, line_valid = 0; a reissued request misses.
- LWA_PERF_CNT_EN:
  - Stimulus: run the sequence cold miss, hit, hit, flush, miss.
  - Required: hit_cnt = 2, miss_cnt = 2.
